// File: rtl/lf_addsub_pipe.sv
// lf_addsub_pipe: three-stage pipelined Ladner-Fischer adder/subtractor.
// S1 forms bitwise P/G (carry-in folded into bit 0) and the first half of the
// prefix levels, S2 finishes the tree into per-bit carries, S3 is the result
// register carrying sum, cout, overflow and zero.
//
// Handshake: a bundle moves across an interface when valid and ready are both
// 1 at a rising clock edge. Each stage loads when it is empty or when its
// current content moves on in the same cycle, so bubbles collapse while the
// output is stalled. in_ready is combinational from out_ready through those
// stage enables (no skid buffer); at most three bundles are held.
module lf_addsub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int L  = $clog2(WIDTH);
    localparam int L1 = (L + 1) / 2;

    // One prefix level k: node i with bit k set absorbs the group ending just
    // below its own aligned 2^k block.
    function automatic logic [2*WIDTH-1:0] lf_level(input logic [WIDTH-1:0] pin,
                                                     input logic [WIDTH-1:0] gin,
                                                     input int k);
        logic [WIDTH-1:0] po;
        logic [WIDTH-1:0] go;
        logic [L-1:0]     jj;
        po = pin;
        go = gin;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i >> k) & 1) == 1) begin
                jj    = L'(((i >> k) << k) - 1);
                po[i] = pin[i] & pin[jj];
                go[i] = gin[i] | (pin[i] & gin[jj]);
            end
        end
        return {po, go};
    endfunction

    // Stage state
    logic             s1_v, s2_v, s3_v;
    logic [WIDTH-1:0] s1_p, s1_pp, s1_gg;
    logic             s1_c0;
    logic [WIDTH-1:0] s2_p, s2_g;
    logic             s2_c0;

    // Stage enables
    logic s1_en, s2_en, s3_en;

    assign s3_en     = out_ready | ~s3_v;
    assign s2_en     = ~s2_v | s3_en;
    assign s1_en     = ~s1_v | s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s3_v;

    // S1 combinational: operand conditioning, P/G, carry-in fold, first levels
    logic [WIDTH-1:0] bx, p_raw, g_fold, pp1, gg1;
    logic             c0;
    always_comb begin
        bx     = op_sub ? ~b : b;
        c0     = op_sub ? 1'b1 : cin;
        p_raw  = a ^ bx;
        g_fold = a & bx;
        g_fold[0] = g_fold[0] | (p_raw[0] & c0);
        pp1 = p_raw;
        gg1 = g_fold;
        for (int k = 0; k < L1; k++) begin
            {pp1, gg1} = lf_level(pp1, gg1, k);
        end
    end

    // S2 combinational: remaining prefix levels yield carry out of every bit
    logic [WIDTH-1:0] pp2, gg2;
    always_comb begin
        pp2 = s1_pp;
        gg2 = s1_gg;
        for (int k = L1; k < L; k++) begin
            {pp2, gg2} = lf_level(pp2, gg2, k);
        end
    end

    // S3 combinational: sum bits use carry into each bit (c0 for bit 0)
    logic [WIDTH-1:0] nxt_sum;
    always_comb begin
        nxt_sum = s2_p ^ {s2_g[WIDTH-2:0], s2_c0};
    end

    // Stage valid bits: the only reset-critical pipeline state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            if (s1_en) s1_v <= in_valid;
            if (s2_en) s2_v <= s1_v;
            if (s3_en) s3_v <= s2_v;
        end
    end

    // S1/S2 data registers, loaded only when a valid bundle enters the stage
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_p  <= p_raw;
            s1_pp <= pp1;
            s1_gg <= gg1;
            s1_c0 <= c0;
        end
        if (s2_en && s1_v) begin
            s2_p  <= s1_p;
            s2_g  <= gg2;
            s2_c0 <= s1_c0;
        end
    end

    // Output register: reset to zero, held stable while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (s3_en && s2_v) begin
            sum      <= nxt_sum;
            cout     <= s2_g[WIDTH-1];
            overflow <= s2_g[WIDTH-2] ^ s2_g[WIDTH-1];
            zero     <= (nxt_sum == '0);
        end
    end

endmodule

// File: tb/tb_lf_addsub_pipe.sv
`timescale 1ns/1ps
// Bench for lf_addsub_pipe: directed vectors with hand-computed results, a
// stall/ordering sequence, a mid-flight reset, and a throttled random run
// against a (WIDTH+1)-bit reference. Expected results queue up at accept time
// and a monitor pops them whenever a result transfers.
module tb_lf_addsub_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, overflow, zero;

  logic [W+2:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         rnd_ready = 1'b0;

  lf_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  // clock: rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: {sum, cout, overflow, zero}
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic mo);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov;
    bb   = mo ? ~mb : mb;
    c0   = mo ? 1'b1 : mc;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
    s    = full[W-1:0];
    ov   = (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
    return {s, full[W], ov, (s == '0)};
  endfunction

  // driver: called at posedge+1, returns at posedge+1 after the accept edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic to, input logic [W+2:0] te);
    int   waitc;
    logic acc;
    waitc = 0;
    acc   = 1'b0;
    a = ta; b = tb_v; cin = tc; op_sub = to; in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(te);
      else begin
        waitc++;
        if (waitc > 200) begin
          n_tests++; n_fail++;
          $display("FAIL accept timeout: in_ready stuck at %b, required 1", in_ready);
          acc = 1'b1;
        end
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  // monitor: compare every transferred result with the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected output: got %h with nothing expected", {sum, cout, overflow, zero});
      end else begin
        check("result", {29'd0, sum, cout, overflow, zero}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  // random output throttling during the regression phase
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : main
    int           idx, nxf, first_t, last_t;
    logic         low_seen, have_prev, acc;
    logic [W+3:0] cur, prev;
    logic [W-1:0] ra, rb;
    logic         rc, ro;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset outputs", {29'd0, sum, cout, overflow, zero}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed add / subtract vectors
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b1});
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h80000000, 1'b0, 1'b1, 1'b0});
    send(32'h00000005, 32'h00000003, 1'b1, 1'b0, {32'h00000009, 1'b0, 1'b0, 1'b0});
    send(32'h80000000, 32'h00000001, 1'b1, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
    send(32'h00001234, 32'h00001234, 1'b0, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b1});
    send(32'h80000000, 32'h80000000, 1'b1, 1'b0, {32'h00000001, 1'b1, 1'b1, 1'b0});
    send(32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0, {32'h0001FFFF, 1'b0, 1'b0, 1'b0});
    drain();

    // back-to-back with output stall: fill, hold, then emit without gaps
    idx = 1; nxf = 0; first_t = -1; last_t = -1;
    low_seen = 1'b0; have_prev = 1'b0; prev = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 1 && c <= 5);
      if (idx <= 5) begin
        in_valid = 1'b1; a = 32'(idx); b = 32'h10; cin = 1'b0; op_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!in_ready) low_seen = 1'b1;
      if (out_valid && out_ready) begin
        nxf++;
        if (first_t < 0) first_t = c;
        last_t = c;
      end
      if (out_valid && !out_ready) begin
        cur = {out_valid, sum, cout, overflow, zero};
        if (have_prev) check("stall hold", 64'(cur), 64'(prev));
        prev = cur;
        have_prev = 1'b1;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back({32'h10 + 32'(idx), 1'b0, 1'b0, 1'b0});
        idx++;
      end
      #1;
    end
    in_valid = 1'b0;
    check("stall in_ready fell", 64'(low_seen), 64'd1);
    check("stall transfers", 64'(nxf), 64'd5);
    check("stall no gaps", 64'(last_t - first_t), 64'd4);
    drain();

    // reset with two bundles in flight
    send(32'h00000100, 32'h00000001, 1'b0, 1'b0, {32'h00000101, 1'b0, 1'b0, 1'b0});
    send(32'h00000200, 32'h00000002, 1'b0, 1'b0, {32'h00000202, 1'b0, 1'b0, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset outputs", {29'd0, sum, cout, overflow, zero}, 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post-reset idle", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // throttled random regression against the reference model
    rnd_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
      send(ra, rb, rc, ro, model(ra, rb, rc, ro));
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lf_addsub_pipe.md
Name: lf_addsub_pipe

Overview:
- Pipelined WIDTH-bit Ladner-Fischer adder/subtractor with valid/ready handshake on input and output.
- Builds its own bitwise P/G terms, runs the log2(WIDTH)-level prefix tree across two register stages, and forms the sum, carry and flags.
- Serves as the registered arithmetic unit on the datapath between operand producers and result consumers.

Parameters:
- WIDTH, 32, operand width; power of two, minimum 8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept the bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when op_sub=0.
- op_sub  input  1  0: A+B+cin; 1: A-B (computed as A+~B+1, cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 means no borrow (A>=B unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset (asynchronous, rst=1) clears all stage valid bits and sets sum/cout/overflow/zero to 0.
  - After reset, in_ready=1 and out_valid=0.
  - A reset mid-operation discards all in-flight bundles. Nothing is emitted after release until new inputs arrive.
- Stage 1 (S1) registers, on accept:
  - b' = op_sub ? ~b : b; c0 = op_sub ? 1 : cin.
  - Bitwise p = a^b', g = a&b'.
  - c0 is folded into bit 0 as g0' = g0 | (p0 & c0).
  - The first ceil(L/2) prefix levels are computed on those terms, where L = log2(WIDTH).
  - S1 also keeps the raw p vector for sum formation.
- Stage 2 (S2) registers:
  - Results of the remaining prefix levels.
  - Final group generates G[i] = carry out of bit i.
  - Raw p.
- Stage 3 (S3, output register) holds:
  - sum[i] = p[i] ^ (i==0 ? c0 : G[i-1]).
  - cout = G[WIDTH-1].
  - overflow = G[WIDTH-2] ^ G[WIDTH-1].
  - zero = (sum==0).
- Prefix combine operator: (P,G)o(P',G') = (P&P', G | P&G'). The tree is the Ladner-Fischer structure: level k combines odd-indexed groups of size 2^k.
- Latency: 3 cycles from accept to out_valid with out_ready held high. Throughput is one bundle per cycle.
- Handshake:
  - Transfer occurs when valid & ready are both 1 at the rising edge.
  - Bubble-collapsing pipeline: stage k loads when it is empty or its content moves to stage k+1 this cycle.
  - S3 advances when out_ready=1 or S3 is empty.
  - in_ready = !S1_valid | S1 advances. It is combinational from out_ready through the stage enables; there is no skid buffer.
- Stall: with out_ready=0, S3 and its outputs stay stable.
  - Upstream stages keep filling bubbles until full. in_ready then falls.
  - Three bundles maximum in flight.
  - Order is strictly preserved; no bundle is dropped or duplicated.
- Data registers in empty stages may hold stale values. Only the valid bits are reset-critical, apart from the output fields, which reset to 0.
- Simultaneous accept and emit in the same cycle is legal and sustains full throughput.

Test Plan:
1. WIDTH=32, add a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> after 3 cycles: sum=0x00000000, cout=1, overflow=0, zero=1.
2. Add a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1, zero=0. Also a=0x00000005, b=0x00000003, cin=1 -> sum=0x00000009, cout=0.
3. Sub a=0x80000000, b=0x00000001, cin=1 (ignored) -> sum=0x7FFFFFFF, cout=1, overflow=1. Also sub a=5, b=7 -> sum=0xFFFFFFFE, cout=0, overflow=0.
4. Back-to-back: 5 bundles on consecutive cycles (a=1..5, b=0x10, add), out_ready=0 from cycle 2 to cycle 6 -> in_ready falls once 3 bundles are held, S3 output is stable while stalled, and sums 0x11..0x15 emerge in order with no gaps once out_ready=1.
5. Reset mid-flight: 2 bundles accepted, rst pulsed between clock edges -> out_valid=0 and all outputs 0 immediately, in_ready=1, and no result appears in the following 5 cycles.
6. Random regression: 10k random a/b/cin/op_sub with random out_ready/in_valid throttling, checked against a behavioural (WIDTH+1)-bit reference for sum, cout, overflow and zero, with ordering checked by scoreboard.
